serial_to_parallel: RTL
=======================

Name: serial_to_parallel

Overview:
- Receive side of the serial board-row link. Collects one bit per enabled clock into a DATA_SIZE-bit word and presents each completed word on a parallel valid/ready output.
- Bit order is LSB first: the first bit received lands in data_out[0].
- Double-buffered: the next word can be shifted in while the previous word waits for the consumer.

Parameters:
- DATA_SIZE, 64, word width in bits; legal range 2 and up.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  1  serial data bit.
- shift_en  input  1  sample data_in this cycle.
- clear  input  1  synchronous abort of the partially collected word.
- data_out  output  DATA_SIZE  completed word (output buffer).
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  consumer accepts data_out when high with out_valid.
- bit_count  output  $clog2(DATA_SIZE+1)  bits collected in the current partial word.
- overrun  output  1  sticky dropped-word flag; present only with S2P_OVERRUN_EN.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of other inputs:
  - shift register = 0, bit_count = 0, data_out = 0, out_valid = 0, overrun = 0.
  - rst has priority over clear and shift_en.
- Shift register sr (DATA_SIZE bits):
  - On shift_en: sr <= {data_in, sr[DATA_SIZE-1:1]}; bit_count increments.
  - After DATA_SIZE shifts, sr[0] is the first bit received.
- Completion: shift_en with bit_count == DATA_SIZE-1 is the completing shift.
  - bit_count wraps to 0 on the same edge.
  - The completed word {data_in, sr[DATA_SIZE-1:1]} is offered to the output buffer on that same edge.
  - out_valid rises the cycle after the final bit is sampled (1-cycle latency).
- Output buffer states:
  - EMPTY (out_valid=0): a completing shift loads data_out and moves to FULL.
  - FULL (out_valid=1), handshake:
    - out_ready=1 consumes the word.
    - Consume without completion on the same edge: go to EMPTY; data_out keeps its stale value.
    - Consume with completion on the same edge: load the new word, stay FULL (out_valid stays 1, no bubble).
    - Completion without consume (out_ready=0): the new word is dropped; data_out and out_valid are unchanged; overrun is set (if built).
  - Shifting continues in FULL; only the buffer load is blocked.
- data_out is stable while out_valid=1 and out_ready=0.
- clear:
  - Sets bit_count <= 0 and sr <= 0; any shift_en on the same cycle is ignored.
  - Does not affect data_out, out_valid or overrun.
- out_ready while out_valid=0 has no effect.
- shift_en=0: sr and bit_count hold; data_in is don't-care.
- bit_count is never equal to DATA_SIZE at an output; range is 0..DATA_SIZE-1.

Optional Feature:
- Macro: S2P_OVERRUN_EN.
- Defined:
  - Output port overrun exists.
  - Set on any completion that occurs while FULL without a consume on the same edge.
  - Stays set until rst; clear does not reset it.
- Undefined:
  - Port and logic absent.
  - The word is still silently dropped under the same condition.

Test Plan (DATA_SIZE=8):
- Basic receive: reset; shift bits 1,0,1,1,0,0,1,0 on consecutive cycles with out_ready=0 → out_valid=1 the cycle after the 8th bit, data_out=8'h4D, bit_count=0.
- Handshake hold and consume: word 8'hA5 valid with out_ready=0 for 5 cycles → data_out stays 8'hA5; then out_ready=1 for one cycle → out_valid=0 on the next cycle.
- Back-to-back, no bubble: out_ready held at 1; stream 8'h3C then 8'hC3 continuously → out_valid high from the first completion onward; data_out=8'h3C, then 8'hC3 exactly 8 cycles later.
- Overrun: complete 8'h11, keep out_ready=0, complete 8'h22 → data_out stays 8'h11, out_valid=1; overrun=1 (macro built); after out_ready pulse, overrun stays 1 until rst.
- Clear mid-word: shift 3 bits, assert clear with shift_en=1 → bit_count=0; then 8 bits forming 8'hF0 → data_out=8'hF0 with no residue from the aborted bits.
- Reset mid-operation: out_valid=1 and bit_count=5, assert rst for one cycle → data_out=0, out_valid=0, bit_count=0, overrun=0; the next full 8 bits receive correctly.

Source files
------------

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: LSB-first shift register with a one-word output buffer on a valid/ready port.
// Optional sticky overrun output is built when S2P_OVERRUN_EN is defined.
module serial_to_parallel #(
   parameter int DATA_SIZE = 64,
   localparam int CW = $clog2(DATA_SIZE + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_in,
   input  logic                 shift_en,
   input  logic                 clear,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        bit_count
`ifdef S2P_OVERRUN_EN
   ,
   output logic                 overrun
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } bufState_t;

   bufState_t            r_state;
   bufState_t            w_nextState;
   logic [DATA_SIZE-1:0] r_shiftReg;
   logic [DATA_SIZE-1:0] r_dataOut;
   logic [CW-1:0]        r_count;
   logic [DATA_SIZE-1:0] w_word;
   logic                 w_shift;
   logic                 w_complete;
   logic                 w_consume;
   logic                 w_load;

   // clear wins over shift_en, so an aborted word can never complete on the clear cycle
   assign w_shift    = shift_en && !clear;
   assign w_complete = w_shift && (r_count == CW'(DATA_SIZE - 1));
   assign w_word     = {data_in, r_shiftReg[DATA_SIZE-1:1]};
   assign w_consume  = (r_state == FULL) && out_ready;

   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_complete) begin
               w_load      = 1'b1;
               w_nextState = FULL;
            end
         end
         FULL: begin
            // A consume on the completing edge refills the buffer without a bubble
            if (w_consume && w_complete) begin
               w_load      = 1'b1;
               w_nextState = FULL;
            end else if (w_consume) begin
               w_nextState = EMPTY;
            end
         end
         default: w_nextState = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= EMPTY;
         r_shiftReg <= '0;
         r_count    <= '0;
         r_dataOut  <= '0;
      end else begin
         r_state <= w_nextState;
         if (clear) begin
            r_shiftReg <= '0;
            r_count    <= '0;
         end else if (w_shift) begin
            r_shiftReg <= w_word;
            r_count    <= w_complete ? '0 : r_count + CW'(1);
         end
         if (w_load) begin
            r_dataOut <= w_word;
         end
      end
   end

`ifdef S2P_OVERRUN_EN
   logic r_overrun;
   logic w_drop;

   assign w_drop = w_complete && (r_state == FULL) && !out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end
   end

   assign overrun = r_overrun;
`endif

   assign data_out  = r_dataOut;
   assign out_valid = (r_state == FULL);
   assign bit_count = r_count;

endmodule
